// File: rtl/scc_fetch_unit.sv
// scc_fetch_unit: SCC instruction fetch front end; define SCC_FETCH_PERF_EN to add the fetch_count port
module scc_fetch_unit #(
   parameter int                ADDR_W     = 32,
   parameter logic [ADDR_W-1:0] RESET_PC   = '0,
   parameter int                FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clk_en,
   output logic              imem_rd_en,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_rdata,
   input  logic              redirect_v,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              halt_req,
   output logic              inst_v,
   output logic [31:0]       inst,
   output logic [ADDR_W-1:0] inst_pc,
   input  logic              inst_rdy,
   output logic              halt_f,
   output logic              fetch_err
`ifdef SCC_FETCH_PERF_EN
   ,
   output logic [31:0]       fetch_count
`endif
);
   localparam int AW = $clog2(FIFO_DEPTH);
   typedef enum logic [1:0] {RUN, DRAIN, HALT, ERR} state_t;
   state_t            state;
   logic [ADDR_W-1:0] pc, inflight_pc;
   logic              inflight;
   logic [31:0]       buf_inst [FIFO_DEPTH];
   logic [ADDR_W-1:0] buf_pc [FIFO_DEPTH];
   logic [AW-1:0]     rd_ptr, wr_ptr;
   logic [AW:0]       count;
   logic [AW+1:0]     occ;
   logic              run, flush, push, pop;
   // Issue/flush decisions; a response landing in a flush cycle is discarded rather than pushed
   always_comb begin
      run        = state == RUN;
      flush      = clk_en && run && (redirect_v || halt_req);
      occ        = {1'b0, count} + (AW+2)'(inflight) - (AW+2)'(inst_v && inst_rdy);
      imem_rd_en = !rst && clk_en && run && !redirect_v && !halt_req && occ < (AW+2)'(FIFO_DEPTH);
      imem_addr  = pc;
      inst_v     = count != '0;
      inst       = inst_v ? buf_inst[rd_ptr] : '0;
      inst_pc    = inst_v ? buf_pc[rd_ptr] : '0;
      halt_f     = state == HALT || state == ERR;
      push       = clk_en && run && inflight && !flush;
      pop        = clk_en && inst_v && inst_rdy && !flush;
   end
   // Instruction buffer storage; contents are only observed through count, so no reset is needed
   always_ff @(posedge clk)
      if (push) begin
         buf_inst[wr_ptr] <= imem_rdata;
         buf_pc[wr_ptr]   <= inflight_pc;
      end
   // PC, in-flight tracking, buffer pointers and fetch state
   always_ff @(posedge clk)
      if (rst) begin
         state       <= RUN;
         pc          <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         fetch_err   <= 1'b0;
      end else if (clk_en) begin
         inflight <= imem_rd_en;
         if (imem_rd_en) begin
            pc          <= pc + ADDR_W'(4);
            inflight_pc <= pc;
         end
         if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            rd_ptr <= rd_ptr + AW'(pop);
            wr_ptr <= wr_ptr + AW'(push);
            count  <= count + (AW+1)'(push) - (AW+1)'(pop);
         end
         if (run && redirect_v) begin
            pc <= redirect_pc;
            if (redirect_pc[1:0] != 2'b00) begin
               fetch_err <= 1'b1;
               state     <= ERR;
            end
         end else if (run && halt_req)
            state <= DRAIN;
         else if (state == DRAIN && !inflight)
            state <= HALT;
      end
`ifdef SCC_FETCH_PERF_EN
   // Count instructions actually delivered to decode
   always_ff @(posedge clk)
      if (rst) fetch_count <= '0;
      else if (pop) fetch_count <= fetch_count + 32'd1;
`endif
endmodule

// File: tb/tb_scc_fetch_unit.sv
// tb_scc_fetch_unit: queue-based reference model plus directed scenarios for scc_fetch_unit
module tb_scc_fetch_unit;
   logic        clk = 0, rst, clk_en, imem_rd_en, redirect_v, halt_req, inst_v, inst_rdy, halt_f, fetch_err;
   logic [31:0] imem_addr, imem_rdata = 0, redirect_pc, inst, inst_pc;
   int          total = 0, bad = 0;
`ifdef SCC_FETCH_PERF_EN
   logic [31:0] fetch_count;
`endif
   scc_fetch_unit dut (
      .clk(clk), .rst(rst), .clk_en(clk_en), .imem_rd_en(imem_rd_en), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .redirect_v(redirect_v), .redirect_pc(redirect_pc), .halt_req(halt_req),
      .inst_v(inst_v), .inst(inst), .inst_pc(inst_pc), .inst_rdy(inst_rdy), .halt_f(halt_f),
      .fetch_err(fetch_err)
`ifdef SCC_FETCH_PERF_EN
      , .fetch_count(fetch_count)
`endif
   );
   always #5 clk = ~clk;
   // memory returns 0x1000_0000 + address one enabled cycle after the request and holds it otherwise
   always @(posedge clk)
      if (clk_en && imem_rd_en) imem_rdata <= 32'h1000_0000 + imem_addr;
   function automatic void check(string n, logic [63:0] a, logic [63:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %h want %h", n, a, e);
      end
   endfunction
   // reference model: buffer as a queue of {word, pc}, mode 0 run, 1 drain, 2 halt, 3 error
   logic [63:0] q[$];
   logic [31:0] m_pc, m_ifpc;
   logic        m_inf, m_err, chk = 0, e_rd, fl, e_pop;
   int          m_mode;
   int unsigned m_pops;
   always @(negedge clk) begin
      e_rd  = !rst && clk_en && m_mode == 0 && !redirect_v && !halt_req &&
              (q.size() + int'(m_inf) - int'(q.size() != 0 && inst_rdy)) < 2;
      fl    = clk_en && m_mode == 0 && (redirect_v || halt_req);
      e_pop = clk_en && q.size() != 0 && inst_rdy && !fl;
      if (chk) begin
         check("rd_en", imem_rd_en, e_rd);
         if (e_rd) check("addr", imem_addr, m_pc);
         check("inst_v", inst_v, q.size() != 0);
         check("inst", inst, q.size() != 0 ? q[0][63:32] : 32'h0);
         check("inst_pc", inst_pc, q.size() != 0 ? q[0][31:0] : 32'h0);
         check("halt_f", halt_f, m_mode >= 2);
         check("fetch_err", fetch_err, m_err);
`ifdef SCC_FETCH_PERF_EN
         check("fetch_count", fetch_count, m_pops);
`endif
      end
      if (rst) begin
         q.delete();
         m_pc = 0; m_ifpc = 0; m_inf = 0; m_err = 0; m_mode = 0; m_pops = 0; chk = 1;
      end else if (clk_en) begin
         if (m_mode == 1 && !m_inf) m_mode = 2;
         if (fl) begin
            q.delete();
            if (redirect_v) begin
               m_pc = redirect_pc;
               if (redirect_pc[1:0] != 0) begin
                  m_err = 1; m_mode = 3;
               end
            end else m_mode = 1;
         end else begin
            if (e_pop) begin
               void'(q.pop_front());
               m_pops++;
            end
            if (m_inf && m_mode == 0) q.push_back({32'h1000_0000 + m_ifpc, m_ifpc});
         end
         m_inf = e_rd;
         if (e_rd) begin
            m_ifpc = m_pc;
            m_pc   = m_pc + 4;
         end
      end
   end
   task automatic nxt(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      logic [31:0] rp = 32'b1011_0010_1110_0110_1001_1101_0011_0111;
      logic [31:0] ep = 32'b1111_1011_1101_1111_0111_1110_1111_1011;
      rst = 1; clk_en = 1; inst_rdy = 1; redirect_v = 0; redirect_pc = 0; halt_req = 0;
      nxt(3);
      @(negedge clk);
      check("rst_inst_v", inst_v, 0); check("rst_rd_en", imem_rd_en, 0); check("rst_halt_f", halt_f, 0);
      check("rst_err", fetch_err, 0); check("rst_inst", inst, 0); check("rst_inst_pc", inst_pc, 0);
      nxt(1); rst = 0;
      @(negedge clk); check("c0_rd_en", imem_rd_en, 1); check("c0_addr", imem_addr, 0);
      nxt(1); @(negedge clk); check("c1_inst_v", inst_v, 0); check("c1_addr", imem_addr, 4);
      nxt(1); @(negedge clk); check("c2_inst_v", inst_v, 1); check("c2_pc", inst_pc, 0); check("c2_inst", inst, 32'h1000_0000);
      nxt(1); @(negedge clk); check("c3_pc", inst_pc, 4); check("c3_inst", inst, 32'h1000_0004);
      nxt(3); inst_rdy = 0;
      nxt(4); @(negedge clk); check("full_rd_en", imem_rd_en, 0); check("full_pc", inst_pc, 16);
      nxt(1); inst_rdy = 1;
      @(negedge clk); check("resume_pc", inst_pc, 16); check("resume_addr", imem_addr, 24);
      nxt(2); @(negedge clk); check("resume_pc2", inst_pc, 24);
      nxt(1); redirect_v = 1; redirect_pc = 32'h40;
      @(negedge clk); check("redir_rd_en", imem_rd_en, 0);
      nxt(1); redirect_v = 0;
      @(negedge clk); check("redir_flush", inst_v, 0); check("redir_addr", imem_addr, 32'h40);
      nxt(2); @(negedge clk); check("redir_pc", inst_pc, 32'h40); check("redir_inst", inst, 32'h1000_0040);
      nxt(1); @(negedge clk); check("redir_pc2", inst_pc, 32'h44);
      nxt(1); clk_en = 0;
      @(negedge clk); check("stall_rd_en", imem_rd_en, 0); check("stall_pc", inst_pc, 32'h48);
      nxt(2); @(negedge clk); check("stall_pc2", inst_pc, 32'h48);
      nxt(1); clk_en = 1;
      @(negedge clk); check("unstall_pc", inst_pc, 32'h48);
      nxt(1); @(negedge clk); check("unstall_pc2", inst_pc, 32'h4C);
      nxt(1); redirect_v = 1; redirect_pc = 32'hFFFF_FFF8;
      nxt(1); redirect_v = 0;
      nxt(2); @(negedge clk); check("wrap_pc0", inst_pc, 32'hFFFF_FFF8);
      nxt(2); @(negedge clk); check("wrap_pc2", inst_pc, 0); check("wrap_inst", inst, 32'h1000_0000);
      nxt(1); halt_req = 1;
      @(negedge clk); check("halt_rd_en", imem_rd_en, 0);
      nxt(1); halt_req = 0;
      @(negedge clk); check("drain_inst_v", inst_v, 0); check("drain_halt_f", halt_f, 0);
      nxt(1); @(negedge clk); check("halt_f", halt_f, 1);
      nxt(1); redirect_v = 1; redirect_pc = 32'h80;
      nxt(1); redirect_v = 0;
      nxt(8); @(negedge clk);
      check("halt_inst_v", inst_v, 0); check("halt_hold", halt_f, 1); check("halt_err", fetch_err, 0);
      rst = 1; nxt(1); rst = 0;
      @(negedge clk); check("rst2_halt_f", halt_f, 0); check("rst2_addr", imem_addr, 0); check("rst2_rd_en", imem_rd_en, 1);
      nxt(2); redirect_v = 1; redirect_pc = 32'h42;
      nxt(1); redirect_v = 0;
      @(negedge clk); check("err_flag", fetch_err, 1); check("err_halt", halt_f, 1); check("err_inst_v", inst_v, 0);
      nxt(5); @(negedge clk); check("err_sticky", fetch_err, 1); check("err_rd_en", imem_rd_en, 0);
      rst = 1; nxt(1); rst = 0;
      @(negedge clk); check("rst3_err", fetch_err, 0); check("rst3_halt", halt_f, 0);
      for (int i = 0; i < 32; i++) begin
         inst_rdy = rp[i]; clk_en = ep[i];
         nxt(1);
      end
      inst_rdy = 1; clk_en = 1;
      nxt(4);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/scc_fetch_unit.md
Name: scc_fetch_unit

Overview:
- Instruction-fetch front end for the SCC core. It sits directly upstream of the decode/execute datapath in scc_f25_top.
- Owns the PC and issues word reads to a synchronous instruction memory with 1-cycle read latency.
- Buffers returned words in a small FIFO and presents them to decode with a valid/ready handshake.
- Handles branch redirects, halt requests and misaligned-target errors.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FIFO_DEPTH, 2, instruction buffer entries. Must be a power of 2 and at least 2.
- ADDR_W, 32, PC/address width.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous active-high reset
- clk_en  input  1  global stall. When 0, all state holds and no new memory request is issued.
- imem_rd_en  output  1  read request to instruction memory
- imem_addr  output  ADDR_W  word-aligned read address
- imem_rdata  input  32  read data, valid the cycle after imem_rd_en && clk_en
- redirect_v  input  1  branch/jump taken; redirect fetch this cycle
- redirect_pc  input  ADDR_W  redirect target
- halt_req  input  1  decode saw HALT; stop fetching
- inst_v  output  1  instruction valid to decode
- inst  output  32  instruction word
- inst_pc  output  ADDR_W  PC of inst
- inst_rdy  input  1  decode accepts inst this cycle
- halt_f  output  1  fetch fully halted
- fetch_err  output  1  sticky misaligned-redirect error

Behaviour:
- Reset, synchronous, takes priority over everything including clk_en=0:
  - pc=RESET_PC; FIFO empty; no request in flight.
  - imem_rd_en=0, inst_v=0, inst=0, inst_pc=0, halt_f=0, fetch_err=0.
- All state updates are qualified by clk_en. With clk_en=0:
  - imem_rd_en=0.
  - Outputs hold their values.
  - An in-flight response is not lost. The memory holds imem_rdata stable while clk_en=0, and the response is captured on the first enabled cycle.
- Request rule: imem_rd_en=1 iff state==RUN && clk_en && (fifo_count + inflight + (inst_v&&inst_rdy ? -1 : 0)) < FIFO_DEPTH && !redirect_v.
  - imem_addr=pc.
  - On issue: pc<=pc+4, inflight<=1, inflight_pc<=pc.
- Response: on the enabled cycle after an issue, if inflight && !drop, push {imem_rdata, inflight_pc} into the FIFO. The FIFO never overflows, by construction of the request rule.
- Output: inst_v = FIFO non-empty. inst/inst_pc = FIFO head. A pop occurs when inst_v && inst_rdy && clk_en.
- A push and a pop in the same cycle are both performed, so the count is unchanged. A push into an empty FIFO is visible at the output the next cycle, giving 2-cycle issue-to-inst_v latency.
- Redirect (redirect_v && clk_en):
  - FIFO is flushed; any pop that cycle is ignored.
  - If a request is in flight, drop<=1 so its response is discarded.
  - pc<=redirect_pc.
  - No request is issued that cycle; fetch resumes the next cycle.
  - Redirect has priority over halt_req in the same cycle.
- Misaligned redirect (redirect_pc[1:0]!=0): fetch_err<=1 (sticky until rst), FIFO flushed, state->ERR.
- FSM states:
  - RUN: normal fetch.
    - RUN->DRAIN on halt_req (without redirect).
    - RUN->ERR on misaligned redirect.
  - DRAIN: no new requests. The outstanding response is discarded and the FIFO is flushed.
    - DRAIN->HALT once inflight==0.
  - HALT: halt_f=1, inst_v=0, imem_rd_en=0. Only rst exits.
  - ERR: same outputs as HALT plus fetch_err=1, halt_f=1. Only rst exits.
- PC wrap: pc+4 wraps modulo 2^ADDR_W with no error.
- Reset asserted mid-request: the response in the next cycle is ignored, because inflight was cleared.

Optional Feature:
- Macro SCC_FETCH_PERF_EN.
- When defined, adds output port fetch_count (32 bits):
  - Increments by 1 on every FIFO pop, i.e. each instruction delivered to decode.
  - Cleared by rst; wraps at 2^32.
  - Holds when clk_en=0.
- When undefined, the port and counter do not exist and all other behaviour is identical.

Test Plan:
- Reset release, memory returns 32'h1000_0000+addr, inst_rdy=1 -> inst_v first high 2 cycles after rst drops, inst_pc=0,4,8,... on consecutive cycles, inst matching.
- inst_rdy=0 for 5 cycles -> FIFO fills to 2, imem_rd_en drops to 0, no address skipped; resuming delivers pc 0,4 then 8.
- Redirect to 32'h40 while a request for pc 8 is in flight -> the pc-8 response is dropped, next inst_pc=32'h40, then 32'h44.
- halt_req at pc 32'h0C -> imem_rd_en=0 from that cycle, halt_f=1 after in-flight completes, inst_v stays 0 for 10 cycles.
- Redirect to 32'h42 -> fetch_err=1, halt_f=1 next cycle; both clear only after rst.
- clk_en toggled 0 for 3 cycles mid-stream -> pc, FIFO and outputs frozen, no duplicate or lost instruction. With SCC_FETCH_PERF_EN, fetch_count equals the number of handshakes.
